// File: rtl/bus_pkg.sv
// Shared types and pin map for the external nibble-bus sequencer.
package bus_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned HI_W     = ADDR_W - NIBBLE_W;
  localparam int unsigned CNT_W    = 3;

  // Bit positions on the uio pin bus
  localparam int unsigned NIB_LSB = 0;
  localparam int unsigned ALE_BIT = 4;
  localparam int unsigned WR_BIT  = 5;
  localparam int unsigned RD_BIT  = 6;
  localparam int unsigned GNT_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A0,
    ST_A1,
    ST_A2,
    ST_WR,
    ST_TURN,
    ST_RD,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [NIBBLE_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; the parent owns the last_grant register.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic       grant,
  output logic       grant_id
);

  always_comb begin
    grant    = enable & (|valid);
    grant_id = valid[1];
    if (valid == 2'b11) grant_id = ~last_grant;
  end

endmodule

// File: rtl/bus_seq_arbiter.sv
// Arbitrates CPU and loader onto the 4-bit uio memory bus and sequences
// each transaction as address nibbles, then a write or read data phase.
module bus_seq_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter bit          SKIP_HI     = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic                req0_we,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [NIBBLE_W-1:0] req0_wdata,
  output logic                req0_ready,
  output logic [NIBBLE_W-1:0] req0_rdata,
  input  logic                req1_valid,
  input  logic                req1_we,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [NIBBLE_W-1:0] req1_wdata,
  output logic                req1_ready,
  output logic [NIBBLE_W-1:0] req1_rdata,
  input  logic [7:0]          uio_in,
  output logic [7:0]          uio_out,
  output logic [7:0]          uio_oe
);

  state_t            state, state_d;
  req_t              cur_q, cur_d;
  logic              gnt_q, gnt_d;
  logic              last_grant;
  logic [HI_W-1:0]   hi_reg;
  logic              hi_valid;
  logic [CNT_W-1:0]  cnt;
  logic              arb_grant, arb_id;
  logic              cnt_last, hi_match;
  logic [7:0]        pin_out_d, pin_oe_d;
  logic [3:0]        unused_pins;

  assign unused_pins = uio_in[7:4];

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .enable     (state == ST_IDLE),
    .grant      (arb_grant),
    .grant_id   (arb_id)
  );

  assign cnt_last = (cnt == CNT_W'(WAIT_STATES));
  assign hi_match = SKIP_HI && hi_valid && (cur_q.addr[ADDR_W-1:NIBBLE_W] == hi_reg);

  // Next state and the transaction latched at grant
  always_comb begin
    state_d = state;
    cur_d   = cur_q;
    gnt_d   = gnt_q;
    case (state)
      ST_IDLE: begin
        if (arb_grant) begin
          state_d     = ST_A0;
          gnt_d       = arb_id;
          cur_d.we    = arb_id ? req1_we    : req0_we;
          cur_d.addr  = arb_id ? req1_addr  : req0_addr;
          cur_d.wdata = arb_id ? req1_wdata : req0_wdata;
        end
      end
      ST_A0:   state_d = hi_match ? (cur_q.we ? ST_WR : ST_TURN) : ST_A1;
      ST_A1:   state_d = ST_A2;
      ST_A2:   state_d = cur_q.we ? ST_WR : ST_TURN;
      ST_WR:   if (cnt_last) state_d = ST_DONE;
      ST_TURN: state_d = ST_RD;
      ST_RD:   if (cnt_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin image for the state being entered, so pins register with the state
  always_comb begin
    pin_out_d = '0;
    pin_oe_d  = 8'hF0;
    if (state_d != ST_IDLE) pin_out_d[GNT_BIT] = gnt_d;
    case (state_d)
      ST_A0: begin
        pin_out_d[NIB_LSB +: NIBBLE_W] = cur_d.addr[NIBBLE_W-1:0];
        pin_out_d[ALE_BIT]             = 1'b1;
        pin_oe_d[NIB_LSB +: NIBBLE_W]  = '1;
      end
      ST_A1: begin
        pin_out_d[NIB_LSB +: NIBBLE_W] = cur_d.addr[2*NIBBLE_W-1:NIBBLE_W];
        pin_out_d[ALE_BIT]             = 1'b1;
        pin_oe_d[NIB_LSB +: NIBBLE_W]  = '1;
      end
      ST_A2: begin
        pin_out_d[NIB_LSB +: NIBBLE_W] = cur_d.addr[ADDR_W-1:2*NIBBLE_W];
        pin_out_d[ALE_BIT]             = 1'b1;
        pin_oe_d[NIB_LSB +: NIBBLE_W]  = '1;
      end
      ST_WR: begin
        pin_out_d[NIB_LSB +: NIBBLE_W] = cur_d.wdata;
        pin_out_d[WR_BIT]              = 1'b1;
        pin_oe_d[NIB_LSB +: NIBBLE_W]  = '1;
      end
      ST_RD:   pin_out_d[RD_BIT] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_q      <= '0;
      gnt_q      <= 1'b0;
      last_grant <= 1'b1;
      hi_reg     <= '0;
      hi_valid   <= 1'b0;
      cnt        <= '0;
      uio_out    <= '0;
      uio_oe     <= 8'hF0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      state   <= state_d;
      cur_q   <= cur_d;
      gnt_q   <= gnt_d;
      uio_out <= pin_out_d;
      uio_oe  <= pin_oe_d;
      if (state == ST_IDLE && arb_grant) last_grant <= arb_id;
      if (state == ST_A2) begin
        hi_reg   <= cur_q.addr[ADDR_W-1:NIBBLE_W];
        hi_valid <= 1'b1;
      end
      // Counts data-phase cycles; zero whenever a data phase is entered
      if ((state == ST_WR || state == ST_RD) && state_d == state) cnt <= cnt + CNT_W'(1);
      else cnt <= '0;
      req0_ready <= (state_d == ST_DONE) && !gnt_d;
      req1_ready <= (state_d == ST_DONE) && gnt_d;
      req0_rdata <= (state_d == ST_DONE && !gnt_d && !cur_q.we) ? uio_in[NIB_LSB +: NIBBLE_W] : '0;
      req1_rdata <= (state_d == ST_DONE && gnt_d && !cur_q.we) ? uio_in[NIB_LSB +: NIBBLE_W] : '0;
    end
  end

endmodule
